// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and flush controller: a shifting in-flight scoreboard of
// downstream producers plus a single multicycle-unit (MUL/DIV) tracker.
module hazard_scoreboard #(
  parameter  int unsigned REG_ADDR_WIDTH = 5,
  parameter  int unsigned DEPTH          = 3,
  parameter  int unsigned ALU_READY      = 2,
  parameter  int unsigned LOAD_READY     = 3,
  parameter  int unsigned MC_CNT_WIDTH   = 6,
  localparam int unsigned FWD_SEL_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic                      rs1_used,
  input  logic                      rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      rd_wen,
  input  logic [1:0]                rd_kind,
  input  logic [MC_CNT_WIDTH-1:0]   mc_latency,
  input  logic                      br_taken,
  output logic                      stall_if,
  output logic                      flush_if,
  output logic                      flush_id,
  output logic [FWD_SEL_WIDTH-1:0]  forward_a_sel,
  output logic [FWD_SEL_WIDTH-1:0]  forward_b_sel,
  output logic                      mc_busy,
  output logic                      mc_wb_en,
  output logic [REG_ADDR_WIDTH-1:0] mc_wb_addr
);

  localparam int unsigned RDY_MAX   = (LOAD_READY > ALU_READY) ? LOAD_READY : ALU_READY;
  localparam int unsigned RDY_WIDTH = $clog2(RDY_MAX + 1);
  // Slot DEPTH is never compared (write-first register file), so only 1..DEPTH-1 are stored.
  localparam int unsigned NSLOT     = (DEPTH > 1) ? DEPTH - 1 : 1;
  localparam logic [1:0]  KIND_LOAD = 2'd1;
  localparam logic [1:0]  KIND_MC   = 2'd2;

  logic                      slot_valid_q [1:NSLOT];
  logic [REG_ADDR_WIDTH-1:0] slot_rd_q    [1:NSLOT];
  logic [RDY_WIDTH-1:0]      slot_rdy_q   [1:NSLOT];

  logic [MC_CNT_WIDTH-1:0]   mc_cnt_q, mc_cnt_d;
  logic [REG_ADDR_WIDTH-1:0] mc_rd_q, mc_rd_d;
  logic [FWD_SEL_WIDTH-1:0]  fwd_a_q, fwd_a_d;
  logic [FWD_SEL_WIDTH-1:0]  fwd_b_q, fwd_b_d;
  logic                      mc_busy_q, mc_wb_en_q;
  logic [REG_ADDR_WIDTH-1:0] mc_wb_addr_q;

  logic [FWD_SEL_WIDTH-1:0]  sel_a, sel_b;
  logic                      haz_a, haz_b, mc_haz;
  logic                      issued, is_mc, mc_pending;
  logic                      entry_valid;
  logic [RDY_WIDTH-1:0]      entry_rdy;
  logic [MC_CNT_WIDTH-1:0]   lat_eff;

  // Youngest matching producer wins: scan oldest to youngest, last hit sticks.
  always_comb begin : src_match
    sel_a = '0;
    haz_a = 1'b0;
    sel_b = '0;
    haz_b = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
      if (rs1_used && rs1_addr != '0 && slot_valid_q[k] && slot_rd_q[k] == rs1_addr) begin
        sel_a = FWD_SEL_WIDTH'(k + 1);
        haz_a = int'(slot_rdy_q[k]) > (k + 1);
      end
      if (rs2_used && rs2_addr != '0 && slot_valid_q[k] && slot_rd_q[k] == rs2_addr) begin
        sel_b = FWD_SEL_WIDTH'(k + 1);
        haz_b = int'(slot_rdy_q[k]) > (k + 1);
      end
    end
  end

  // Multicycle hazards only while the result is more than one cycle away.
  always_comb begin : mc_hazard
    mc_pending = mc_cnt_q > MC_CNT_WIDTH'(1);
    is_mc      = rd_kind == KIND_MC;
    mc_haz     = 1'b0;
    if (mc_pending) begin
      mc_haz = (rs1_used && rs1_addr != '0 && rs1_addr == mc_rd_q) ||
               (rs2_used && rs2_addr != '0 && rs2_addr == mc_rd_q) ||
               (rd_wen && mc_rd_q != '0 && rd_addr == mc_rd_q) ||
               is_mc;
    end
  end

  assign stall_if = issue_valid & ~br_taken & (haz_a | haz_b | mc_haz);
  assign flush_if = br_taken;
  assign flush_id = br_taken;
  assign issued   = issue_valid & ~stall_if & ~br_taken;

  always_comb begin : next_state
    entry_valid = issued && rd_wen && rd_addr != '0 && !is_mc;
    entry_rdy   = (rd_kind == KIND_LOAD) ? RDY_WIDTH'(LOAD_READY) : RDY_WIDTH'(ALU_READY);
    lat_eff     = (mc_latency == '0) ? MC_CNT_WIDTH'(1) : mc_latency;
    mc_cnt_d    = mc_cnt_q;
    mc_rd_d     = mc_rd_q;
    if (issued && is_mc) begin
      mc_cnt_d = lat_eff;
      mc_rd_d  = rd_addr;
    end else if (mc_cnt_q != '0) begin
      mc_cnt_d = mc_cnt_q - MC_CNT_WIDTH'(1);
    end
    fwd_a_d = issued ? sel_a : '0;
    fwd_b_d = issued ? sel_b : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin : slot_shift
    if (!rst_n) begin
      for (int k = 1; k <= int'(NSLOT); k++) begin
        slot_valid_q[k] <= 1'b0;
        slot_rd_q[k]    <= '0;
        slot_rdy_q[k]   <= '0;
      end
    end else begin
      for (int k = int'(NSLOT); k >= 2; k--) begin
        slot_valid_q[k] <= slot_valid_q[k-1];
        slot_rd_q[k]    <= slot_rd_q[k-1];
        slot_rdy_q[k]   <= slot_rdy_q[k-1];
      end
      slot_valid_q[1] <= entry_valid;
      slot_rd_q[1]    <= entry_valid ? rd_addr : '0;
      slot_rdy_q[1]   <= entry_valid ? entry_rdy : '0;
    end
  end

  // Status outputs are registered from next-state so they track mc_cnt exactly.
  always_ff @(posedge clk or negedge rst_n) begin : state_regs
    if (!rst_n) begin
      mc_cnt_q     <= '0;
      mc_rd_q      <= '0;
      fwd_a_q      <= '0;
      fwd_b_q      <= '0;
      mc_busy_q    <= 1'b0;
      mc_wb_en_q   <= 1'b0;
      mc_wb_addr_q <= '0;
    end else begin
      mc_cnt_q     <= mc_cnt_d;
      mc_rd_q      <= mc_rd_d;
      fwd_a_q      <= fwd_a_d;
      fwd_b_q      <= fwd_b_d;
      mc_busy_q    <= mc_cnt_d != '0;
      mc_wb_en_q   <= mc_cnt_d == MC_CNT_WIDTH'(1);
      mc_wb_addr_q <= (mc_cnt_d == MC_CNT_WIDTH'(1)) ? mc_rd_d : '0;
    end
  end

  assign forward_a_sel = fwd_a_q;
  assign forward_b_sel = fwd_b_q;
  assign mc_busy       = mc_busy_q;
  assign mc_wb_en      = mc_wb_en_q;
  assign mc_wb_addr    = mc_wb_addr_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard, forwarding and flush controller for the RISC-V pipeline. It replaces fixed EXE/MEM/WB address compares with a DEPTH-slot in-flight scoreboard. Per-slot readiness generalises load-use stalls to any result latency, and a multicycle-unit tracker (MUL/DIV) adds busy and writeback stalls. It sits beside decode: it consumes the decoded instruction's register fields and the execute-stage branch outcome, and drives IF/ID stall/flush and the registered execute-stage forwarding selects.

## Interface
- REG_ADDR_WIDTH, 5, register address width
- DEPTH, 3, tracked slots downstream of decode (1 = EXE … DEPTH = WB)
- ALU_READY, 2, first slot index at which an ALU result is forwardable
- LOAD_READY, 3, first slot index at which a load result is forwardable
- MC_CNT_WIDTH, 6, multicycle latency counter width
- FWD_SEL_WIDTH (local), $clog2(DEPTH+1)

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  valid instruction in decode
- rs1_addr, rs2_addr  in  REG_ADDR_WIDTH  decode source registers
- rs1_used, rs2_used  in  1  source actually read
- rd_addr  in  REG_ADDR_WIDTH  decode destination
- rd_wen  in  1  instruction writes rd
- rd_kind  in  2  0 = ALU, 1 = load, 2 = multicycle, 3 = reserved (treated as ALU)
- mc_latency  in  MC_CNT_WIDTH  multicycle latency in cycles; 0 is treated as 1
- br_taken  in  1  execute-stage redirect
- stall_if  out  1  hold PC and IF/ID register
- flush_if  out  1  squash IF/ID contents
- flush_id  out  1  squash the decode instruction (bubble into EXE)
- forward_a_sel, forward_b_sel  out  FWD_SEL_WIDTH  execute operand source: 0 = register file, k = slot k result
- mc_busy  out  1  multicycle unit occupied (count != 0)
- mc_wb_en  out  1  multicycle writeback strobe
- mc_wb_addr  out  REG_ADDR_WIDTH  multicycle destination

## Operation
- Slot entry: {valid, rd, ready_slot}. ready_slot is ALU_READY for ALU and LOAD_READY for load. Multicycle instructions enter a slot with valid = 0, because their writeback uses a dedicated port.
- Every cycle, slots shift: slot[k+1] <= slot[k]; slot[DEPTH] retires. slot[1] <= decode entry if issued, else a bubble.
- issued = issue_valid & !stall_if & !br_taken.
- An entry is valid only when rd_wen & rd_addr != 0.
- The register file is write-first, so slot DEPTH is never checked.
- Source match, for a used source r != 0:
  - k = smallest index in 1..DEPTH-1 with slot[k].valid & slot[k].rd == r (the youngest producer wins).
  - Hazard if ready_slot > k+1; otherwise the forward select is k+1.
  - No match gives select 0.
- Multicycle tracker: on issue of a kind 2 instruction, mc_cnt <= max(mc_latency, 1) and mc_rd <= rd_addr. mc_cnt decrements while non-zero.
  - mc_wb_en = (mc_cnt == 1) and mc_wb_addr = mc_rd, valid only while mc_cnt == 1.
  - RAW hazard on mc_rd while mc_cnt > 1.
  - WAW hazard (decode rd_wen & rd_addr == mc_rd != 0) while mc_cnt > 1.
  - Structural hazard: a kind 2 instruction in decode while mc_cnt > 1.
- stall_if = issue_valid & !br_taken & (any slot hazard | any multicycle hazard).
- flush_if = flush_id = br_taken. Flush overrides stall.
- A flushed or stalled decode instruction inserts a bubble and never loads the mc tracker.
- forward_*_sel registers the computed select when issued, else 0.

## Timing
- Reset (async, rst_n low): all slots invalid, mc_cnt = 0, mc_rd = 0, forward selects 0. stall_if, flush_if, flush_id, mc_busy and mc_wb_en all 0.
- stall_if, flush_if and flush_id are combinational in the same cycle as the decode inputs.
- Forward selects take effect one cycle later, aligned with the consumer in EXE.
- Load-use at defaults gives exactly 1 stall cycle; an ALU producer gives 0.
- Multicycle with latency L issued at cycle t: mc_wb_en is high at cycle t+L. Dependent decode stalls through t+L-1 and issues at t+L at the earliest.
- Back-to-back multicycle instructions: the second issues at t+L at the earliest (mc_cnt == 1 is not busy for hazards).
- Reset mid-operation discards all in-flight state immediately. The first post-reset cycle sees no hazards.

## Test plan
- ALU chain: x5 = ALU op, then the next instruction reads rs1 = x5 → no stall; forward_a_sel = 2 the following cycle. A reader two instructions later gets select 3. A reader three instructions later gets select 0.
- Load-use: load x7, then add x8, x7, x7 → stall_if high for 1 cycle. Next cycle a bubble enters EXE, then forward_a_sel = forward_b_sel = 3.
- x0 and the unused rs2 field: load x0, then rs1 = x0 and rs2_used = 0 with rs2 matching → no stall, selects 0.
- Multicycle: MUL x9 with mc_latency = 4, then a reader of x9 → stall 3 cycles. mc_wb_en pulses with mc_wb_addr = 9 at the 4th cycle, when the reader issues with select 0. A WAW write to x9 behaves identically.
- Branch during stall: a load-use stall with br_taken asserted → stall_if = 0, flush_if = flush_id = 1, the bubble is inserted, and the load is still tracked.
- Reset mid-multicycle: drop rst_n with mc_cnt = 3 → mc_busy, mc_wb_en and all selects go to 0 asynchronously, and no writeback occurs.
